// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - single-word bus requester: arbitrate, one-cycle address strobe, wait for ready or time out
// Every output is a flop loaded from the next-state decode, so the bus sees clean edges.
module bus_master_if #(
   parameter int ADDR_W  = 30,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_rw,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wr_data,
   output logic [DATA_W-1:0] core_rd_data,
   output logic              core_busy,
   output logic              core_done,
   output logic              core_err,
   output logic              req_,
   input  logic              grnt_,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_as_,
   output logic              bus_rw,
   output logic [DATA_W-1:0] bus_wr_data,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              rdy_
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ADDR, S_WAIT} state_t;

   state_t              state, state_nxt;
   logic                lat_rw, lat_rw_nxt;
   logic [ADDR_W-1:0]   lat_addr, lat_addr_nxt;
   logic [DATA_W-1:0]   lat_wdata, lat_wdata_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
   logic [DATA_W-1:0]   rd_nxt;
   logic                done_nxt, err_nxt;
   logic                busy_nxt, as_nxt, rw_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [DATA_W-1:0]   wdata_nxt;

   assign cnt_inc = cnt + CNT_W'(1);

   always_comb begin
      state_nxt     = state;
      lat_rw_nxt    = lat_rw;
      lat_addr_nxt  = lat_addr;
      lat_wdata_nxt = lat_wdata;
      cnt_nxt       = cnt;
      rd_nxt        = core_rd_data;
      done_nxt      = 1'b0;
      err_nxt       = 1'b0;

      case (state)
         S_IDLE: begin
            if (core_req) begin
               lat_rw_nxt    = core_rw;
               lat_addr_nxt  = core_addr;
               lat_wdata_nxt = core_wr_data;
               state_nxt     = S_REQ;
            end
         end
         S_REQ: begin
            if (!grnt_) state_nxt = S_ADDR;
         end
         S_ADDR: begin
            cnt_nxt   = '0;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            cnt_nxt = cnt_inc;
            if (!rdy_) begin
               if (lat_rw) rd_nxt = bus_rd_data;
               done_nxt  = 1'b1;
               state_nxt = S_IDLE;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               // exactly TIMEOUT waiting cycles without ready have elapsed
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      busy_nxt  = (state_nxt != S_IDLE);
      as_nxt    = (state_nxt != S_ADDR);
      addr_nxt  = (state_nxt == S_ADDR) ? lat_addr_nxt  : '0;
      rw_nxt    = (state_nxt == S_ADDR) ? lat_rw_nxt    : 1'b1;
      wdata_nxt = (state_nxt == S_ADDR) ? lat_wdata_nxt : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         lat_rw       <= 1'b1;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         cnt          <= '0;
         core_rd_data <= '0;
         core_busy    <= 1'b0;
         core_done    <= 1'b0;
         core_err     <= 1'b0;
         req_         <= 1'b1;
         bus_as_      <= 1'b1;
         bus_rw       <= 1'b1;
         bus_addr     <= '0;
         bus_wr_data  <= '0;
      end else begin
         state        <= state_nxt;
         lat_rw       <= lat_rw_nxt;
         lat_addr     <= lat_addr_nxt;
         lat_wdata    <= lat_wdata_nxt;
         cnt          <= cnt_nxt;
         core_rd_data <= rd_nxt;
         core_busy    <= busy_nxt;
         core_done    <= done_nxt;
         core_err     <= err_nxt;
         // ownership is held for the whole transaction, so req_ simply tracks busy
         req_         <= !busy_nxt;
         bus_as_      <= as_nxt;
         bus_rw       <= rw_nxt;
         bus_addr     <= addr_nxt;
         bus_wr_data  <= wdata_nxt;
      end
   end

endmodule

// File: tb/tb_bus_master_if.sv
// tb/tb_bus_master_if.sv - bench for bus_master_if: directed table, randomized transactions, reset-in-wait sequence
module tb_bus_master_if;

   localparam int ADDR_W  = 30;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              core_req, core_rw;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wr_data, core_rd_data;
   logic              core_busy, core_done, core_err;
   logic              req_, grnt_, bus_as_, bus_rw, rdy_;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wr_data, bus_rd_data;

   bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_rw(core_rw), .core_addr(core_addr),
      .core_wr_data(core_wr_data), .core_rd_data(core_rd_data),
      .core_busy(core_busy), .core_done(core_done), .core_err(core_err),
      .req_(req_), .grnt_(grnt_),
      .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
      .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .rdy_(rdy_)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] model_rd;

   typedef struct {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      int                g;      // cycles grant is withheld
      int                w;      // cycles ready is withheld
      logic [DATA_W-1:0] rdata;
      bit                noise;  // randomize every ignored input
      bit                hold;   // keep core_req high into the next transaction
      bit                exp_ok;
      logic [DATA_W-1:0] exp_rd;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%h want=%h t=%0t", name, k, act, exp, $time);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, 0, 32'(core_busy), 32'(0));
      chk({tag, "_req_"}, 0, 32'(req_), 32'(1));
      chk({tag, "_as_"}, 0, 32'(bus_as_), 32'(1));
      chk({tag, "_rw"}, 0, 32'(bus_rw), 32'(1));
      chk({tag, "_addr"}, 0, 32'(bus_addr), 32'(0));
      chk({tag, "_wdata"}, 0, bus_wr_data, 32'(0));
      chk({tag, "_rd"}, 0, core_rd_data, 32'(0));
      chk({tag, "_done"}, 0, 32'(core_done), 32'(0));
      chk({tag, "_err"}, 0, 32'(core_err), 32'(0));
   endtask

   // Drives one transaction on a fixed timeline and checks every output each cycle.
   // Edge k=0 accepts the request; address strobe follows edge 1+g; completion at edge L.
   task automatic run_txn(input vec_t v);
      int L, ak, j;
      L  = v.exp_ok ? 3 + v.g + v.w : 2 + v.g + TIMEOUT;
      ak = 1 + v.g;
      for (int k = 0; k <= L; k++) begin
         @(negedge clk);
         if (k == 0) begin
            core_req = 1'b1; core_rw = v.rw; core_addr = v.addr; core_wr_data = v.wdata;
         end else begin
            core_req = v.hold ? 1'b1 : (v.noise ? 1'($urandom) : 1'b0);
            if (v.noise) begin
               core_rw = 1'($urandom); core_addr = 30'($urandom); core_wr_data = $urandom;
            end
         end
         if (k >= 1 && k <= v.g)  grnt_ = 1'b1;
         else if (k == 1 + v.g)   grnt_ = 1'b0;
         else                     grnt_ = v.noise ? 1'($urandom) : 1'b0;
         j = k - 3 - v.g;
         if (j >= 0)              rdy_ = (j == v.w) ? 1'b0 : 1'b1;
         else                     rdy_ = v.noise ? 1'($urandom) : 1'b1;
         bus_rd_data = (k == L) ? v.rdata : $urandom;
         @(posedge clk); #1;
         if (k == L) model_rd = v.exp_rd;
         chk("busy", k, 32'(core_busy), 32'(k < L));
         chk("req_", k, 32'(req_), 32'(k >= L));
         chk("as_", k, 32'(bus_as_), 32'(k != ak));
         chk("bus_addr", k, 32'(bus_addr), (k == ak) ? 32'(v.addr) : 32'(0));
         chk("bus_rw", k, 32'(bus_rw), (k == ak) ? 32'(v.rw) : 32'(1));
         chk("bus_wdata", k, bus_wr_data, (k == ak) ? v.wdata : 32'(0));
         chk("done", k, 32'(core_done), 32'(k == L && v.exp_ok));
         chk("err", k, 32'(core_err), 32'(k == L && !v.exp_ok));
         chk("rd_data", k, core_rd_data, model_rd);
      end
      if (!v.hold) core_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      vec_t r;
      reset = 1'b1; core_req = 1'b0; core_rw = 1'b0; core_addr = '0; core_wr_data = '0;
      grnt_ = 1'b1; rdy_ = 1'b1; bus_rd_data = '0;
      model_rd = '0;

      vecs[0] = '{1'b1, 30'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 30'h3FF, 32'h12345678, 5, 1, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 30'h055, 32'h0, 1, TIMEOUT, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 30'h056, 32'h0, 0, TIMEOUT - 1, 32'h0BADF00D, 1'b0, 1'b0, 1'b1, 32'h0BADF00D};
      vecs[4] = '{1'b1, 30'h200, 32'h0, 3, 2, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5};
      vecs[5] = '{1'b1, 30'h201, 32'h0, 0, 0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1, 32'h5A5A5A5A};
      vecs[6] = '{1'b0, 30'h2AA, 32'hFEEDFACE, 2, 10, 32'h22222222, 1'b1, 1'b0, 1'b0, 32'h5A5A5A5A};

      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) run_txn(vecs[i]);

      for (int i = 0; i < 40; i++) begin
         r.rw     = 1'($urandom);
         r.addr   = 30'($urandom);
         r.wdata  = $urandom;
         r.g      = $urandom_range(0, 3);
         r.w      = $urandom_range(0, TIMEOUT + 2);
         r.rdata  = $urandom;
         r.noise  = 1'b1;
         r.hold   = (i != 39) && ($urandom_range(0, 3) == 0);
         r.exp_ok = (r.w < TIMEOUT);
         r.exp_rd = (r.exp_ok && r.rw) ? r.rdata : model_rd;
         run_txn(r);
      end

      // reset while waiting for ready: abort silently, later ready is ignored
      @(negedge clk);
      core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h2A; grnt_ = 1'b0; rdy_ = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      core_req = 1'b0;
      @(posedge clk); #1;
      chk("rw_addr_as_", 1, 32'(bus_as_), 32'(0));
      @(posedge clk); #1;
      chk("rw_wait_busy", 2, 32'(core_busy), 32'(1));
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_vals("rst_wait");
      model_rd = '0;
      @(negedge clk);
      reset = 1'b0; rdy_ = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("late_rdy_done", k, 32'(core_done), 32'(0));
         chk("late_rdy_busy", k, 32'(core_busy), 32'(0));
         chk("late_rdy_req_", k, 32'(req_), 32'(1));
      end
      @(negedge clk);
      rdy_ = 1'b1;

      r = '{1'b1, 30'h3C, 32'h0, 1, 0, 32'h600DCAFE, 1'b0, 1'b0, 1'b1, 32'h600DCAFE};
      run_txn(r);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
